// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared raster constants and pacing FSM state type for the playfield
package game_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int NSPR_DEFAULT = 4;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        EVAL = 2'd1,
        WAIT = 2'd2
    } pacer_state_e;

endpackage

// File: rtl/playfield_arbiter_if.sv
// rtl/playfield_arbiter_if.sv - raster/sprite bundle between timing generator, sprites and arbiter
interface playfield_arbiter_if #(
    parameter int NSPR = 4
);
    logic            pixpulse;
    logic [9:0]      hcount;
    logic [9:0]      vcount;
    logic [NSPR-1:0] draw;
    logic            enable;
    logic [NSPR-1:0] empty;
    logic            move;
    logic            wall_px;
    logic [NSPR-1:0] collide;
    logic [7:0]      hits;

    modport master (
        output pixpulse, hcount, vcount, draw, enable,
        input  empty, move, wall_px, collide, hits
    );

    modport slave (
        input  pixpulse, hcount, vcount, draw, enable,
        output empty, move, wall_px, collide, hits
    );
endinterface

// File: rtl/frame_pacer.sv
// rtl/frame_pacer.sv - per-frame SCAN/EVAL/WAIT sequencer with move divider
module frame_pacer
    import game_pkg::*;
#(
    parameter int V_ACTIVE = game_pkg::V_ACTIVE,
    parameter int MOVE_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       enable,
    output logic       move,
    output logic       eval
);

    pacer_state_e state_q, state_d;
    logic [7:0]   div_q, div_d;
    logic         move_q, move_d;
    logic         eval_q, eval_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        move_d  = move_q;
        eval_d  = eval_q;
        if (pixpulse) begin
            case (state_q)
                SCAN: begin
                    if (vcount == 10'(V_ACTIVE) && hcount == 10'd0) begin
                        state_d = EVAL;
                        eval_d  = 1'b1;
                    end
                end
                EVAL: begin
                    // divider keeps counting while disabled so re-enable stays in phase
                    if (div_q == 8'(MOVE_DIV - 1)) begin
                        div_d  = 8'd0;
                        move_d = enable;
                    end else begin
                        div_d  = div_q + 8'd1;
                        move_d = 1'b0;
                    end
                    state_d = WAIT;
                    eval_d  = 1'b0;
                end
                WAIT: begin
                    move_d = 1'b0;
                    if (vcount == 10'd0 && hcount == 10'd0) begin
                        state_d = SCAN;
                    end
                end
                default: begin
                    state_d = SCAN;
                    eval_d  = 1'b0;
                    move_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            div_q   <= 8'd0;
            move_q  <= 1'b0;
            eval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            move_q  <= move_d;
            eval_q  <= eval_d;
        end
    end

    assign move = move_q;
    assign eval = eval_q;

endmodule

// File: rtl/playfield_arbiter.sv
// rtl/playfield_arbiter.sv - wall/sprite occupancy, per-frame collision report and move pacing
module playfield_arbiter
    import game_pkg::*;
#(
    parameter int NSPR     = game_pkg::NSPR_DEFAULT,
    parameter int H_ACTIVE = game_pkg::H_ACTIVE,
    parameter int V_ACTIVE = game_pkg::V_ACTIVE,
    parameter int WALL     = 2,
    parameter int MOVE_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    playfield_arbiter_if.slave   bus
);

    logic            visible;
    logic            wall;
    logic            multi;
    logic [NSPR-1:0] empty_c;
    logic [NSPR-1:0] pend_q, pend_d;
    logic [NSPR-1:0] collide_q, collide_d;
    logic [7:0]      hits_q, hits_d;
    logic            eval;
    logic            move;

    frame_pacer #(
        .V_ACTIVE (V_ACTIVE),
        .MOVE_DIV (MOVE_DIV)
    ) u_pacer (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixpulse (bus.pixpulse),
        .hcount   (bus.hcount),
        .vcount   (bus.vcount),
        .enable   (bus.enable),
        .move     (move),
        .eval     (eval)
    );

    always_comb begin
        visible = (bus.hcount < 10'(H_ACTIVE)) && (bus.vcount < 10'(V_ACTIVE));
        wall    = visible && ((bus.hcount < 10'(WALL)) ||
                              (bus.hcount >= 10'(H_ACTIVE - WALL)) ||
                              (bus.vcount < 10'(WALL)) ||
                              (bus.vcount >= 10'(V_ACTIVE - WALL)));
        // clearing the lowest set bit leaves something only if two or more sprites are drawn
        multi   = |(bus.draw & (bus.draw - NSPR'(1)));
        empty_c = '1;
        for (int i = 0; i < NSPR; i++) begin
            empty_c[i] = !visible || !(wall || (|(bus.draw & ~(NSPR'(1) << i))));
        end
    end

    always_comb begin
        pend_d    = pend_q;
        collide_d = collide_q;
        hits_d    = hits_q;
        if (bus.pixpulse) begin
            if (eval) begin
                collide_d = pend_q;
                pend_d    = '0;
                if ((|pend_q) && hits_q != 8'hFF) begin
                    hits_d = hits_q + 8'd1;
                end
            end else if (visible && multi) begin
                pend_d = pend_q | bus.draw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            collide_q <= '0;
            hits_q    <= 8'd0;
        end else begin
            pend_q    <= pend_d;
            collide_q <= collide_d;
            hits_q    <= hits_d;
        end
    end

    assign bus.empty   = empty_c;
    assign bus.wall_px = wall;
    assign bus.move    = move;
    assign bus.collide = collide_q;
    assign bus.hits    = hits_q;

endmodule

// File: tb/tb_playfield_arbiter.sv
// tb/tb_playfield_arbiter.sv - scoreboard bench for playfield_arbiter (MOVE_DIV 1 and 3)
module tb_playfield_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixpulse;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [3:0] draw;
    logic       enable;

    always #5 clk = ~clk;

    playfield_arbiter_if #(.NSPR(4)) bus1 ();
    playfield_arbiter_if #(.NSPR(4)) bus3 ();

    assign bus1.pixpulse = pixpulse;
    assign bus1.hcount   = hcount;
    assign bus1.vcount   = vcount;
    assign bus1.draw     = draw;
    assign bus1.enable   = enable;
    assign bus3.pixpulse = pixpulse;
    assign bus3.hcount   = hcount;
    assign bus3.vcount   = vcount;
    assign bus3.draw     = draw;
    assign bus3.enable   = enable;

    playfield_arbiter #(.NSPR(4), .MOVE_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    playfield_arbiter #(.NSPR(4), .MOVE_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int errors = 0;
    int checks = 0;
    int mv_cnt1, mv_cnt3;

    // reference model state
    logic [3:0] m_collide;
    int         m_hits;
    int         m_div1, m_div3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_entry_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, act, e.exp);
        end
    endtask

    function automatic logic [3:0] ref_empty(input int h, input int v, input logic [3:0] d);
        logic vis, w;
        logic [3:0] r;
        vis = (h < 640) && (v < 480);
        w   = vis && (h < 2 || h >= 638 || v < 2 || v >= 478);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] others;
            others = d;
            others[i] = 1'b0;
            r[i] = !vis || !(w || (others != 4'd0));
        end
        return r;
    endfunction

    // combinational look-up, usable while reset is held
    task automatic comb(input int h, input int v, input logic [3:0] d, input logic exp_wall);
        hcount = 10'(h);
        vcount = 10'(v);
        draw   = d;
        sb_push("wall_px", {31'd0, exp_wall});
        sb_push("empty", {28'd0, ref_empty(h, v, d)});
        #1;
        sb_pop_check({31'd0, bus1.wall_px});
        sb_pop_check({28'd0, bus1.empty});
    endtask

    task automatic pix(input int h, input int v, input logic [3:0] d);
        @(posedge clk);
        #1;
        hcount   = 10'(h);
        vcount   = 10'(v);
        draw     = d;
        pixpulse = 1'b1;
        #1;
        if (bus1.move) mv_cnt1++;
        if (bus3.move) mv_cnt3++;
        @(posedge clk);
        #1;
        pixpulse = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic run_frame(input logic [3:0] ov, input int n);
        logic [3:0] ovm1;
        logic [3:0] pend_m;
        int exp_mv1, exp_mv3;
        ovm1   = ov - 4'd1;
        pend_m = (n > 0 && (ov & ovm1) != 4'd0) ? ov : 4'd0;
        m_collide = pend_m;
        if (pend_m != 4'd0 && m_hits < 255) m_hits++;
        if (m_div1 == 0) begin m_div1 = 0; exp_mv1 = int'(enable); end
        else begin m_div1++; exp_mv1 = 0; end
        if (m_div3 == 2) begin m_div3 = 0; exp_mv3 = int'(enable); end
        else begin m_div3++; exp_mv3 = 0; end
        sb_push("collide1", {28'd0, m_collide});
        sb_push("hits1", 32'(m_hits));
        sb_push("collide3", {28'd0, m_collide});
        sb_push("move1_count", 32'(exp_mv1));
        sb_push("move3_count", 32'(exp_mv3));
        mv_cnt1 = 0;
        mv_cnt3 = 0;
        pix(0, 0, 4'd0);
        for (int k = 0; k < n; k++) pix(100 + k, 100, ov);
        pix(5, 300, 4'd0);
        pix(0, 480, 4'd0);
        pix(1, 480, 4'd0);
        pix(2, 480, 4'd0);
        pix(3, 480, 4'd0);
        sb_pop_check({28'd0, bus1.collide});
        sb_pop_check({24'd0, bus1.hits});
        sb_pop_check({28'd0, bus3.collide});
        sb_pop_check(32'(mv_cnt1));
        sb_pop_check(32'(mv_cnt3));
    endtask

    initial begin
        rst_n     = 1'b0;
        pixpulse  = 1'b0;
        hcount    = 10'd0;
        vcount    = 10'd0;
        draw      = 4'd0;
        enable    = 1'b1;
        m_collide = 4'd0;
        m_hits    = 0;
        m_div1    = 0;
        m_div3    = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_move", {31'd0, bus1.move}, 32'd0);
        check("reset_collide", {28'd0, bus1.collide}, 32'd0);
        check("reset_hits", {24'd0, bus1.hits}, 32'd0);

        comb(1, 100, 4'b0000, 1'b1);
        comb(2, 100, 4'b0000, 1'b0);
        comb(100, 100, 4'b0001, 1'b0);
        comb(100, 100, 4'b0011, 1'b0);
        comb(100, 100, 4'b0100, 1'b0);
        comb(637, 100, 4'b0000, 1'b0);
        comb(638, 100, 4'b0010, 1'b1);
        comb(300, 477, 4'b0000, 1'b0);
        comb(300, 478, 4'b0000, 1'b1);
        comb(300, 1, 4'b1000, 1'b1);
        comb(700, 100, 4'b0111, 1'b0);
        comb(100, 500, 4'b1111, 1'b0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame(4'b0101, 10);
        run_frame(4'b0000, 0);
        run_frame(4'b0011, 3);
        run_frame(4'b1110, 2);
        run_frame(4'b0100, 5);
        enable = 1'b0;
        run_frame(4'b0000, 0);
        run_frame(4'b0000, 0);
        enable = 1'b1;
        run_frame(4'b0000, 0);
        run_frame(4'b0000, 0);
        run_frame(4'b0000, 0);

        // asynchronous reset in the middle of a frame with pending overlap
        pix(0, 0, 4'd0);
        pix(100, 200, 4'b0101);
        pix(101, 200, 4'b0101);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_move", {31'd0, bus1.move}, 32'd0);
        check("midrst_collide", {28'd0, bus1.collide}, 32'd0);
        check("midrst_hits", {24'd0, bus1.hits}, 32'd0);
        m_hits    = 0;
        m_div1    = 0;
        m_div3    = 0;
        m_collide = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(4'b0101, 10);
        run_frame(4'b0000, 0);

        for (int f = 0; f < 260; f++) run_frame(4'b0011, 1);
        check("hits_saturated", {24'd0, bus1.hits}, 32'd255);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
